// File: rtl/ckgate_ctrl.sv
// rtl/ckgate_ctrl.sv - multi-channel idle-driven clock-gating controller with per-channel latch gate
// Define CKGATE_BYPASS_EN to pass clk_i straight to every clk_o (no latch); FSM behaviour is unchanged.
module ckgate_ctrl #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CNT_W-1:0]  idle_thr_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [NUM_CH-1:0] wake_i,
   input  logic [NUM_CH-1:0] force_on_i,
   output logic [NUM_CH-1:0] en_o,
   output logic [NUM_CH-1:0] ready_o,
   output logic [NUM_CH-1:0] clk_o
);

   typedef enum logic [1:0] {
      ST_ON    = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OFF   = 2'd2,
      ST_WAKE  = 2'd3
   } state_e;

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] ready_q, ready_d;
   logic [NUM_CH-1:0] act;

   assign act = busy_i | wake_i | force_on_i;

   // Increment is evaluated one bit wider so the threshold compare never sees a wrapped count.
   always_comb begin
      logic [CNT_W:0] cnt_inc;
      cnt_inc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         cnt_inc    = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
         case (state_q[i])
            ST_ON: begin
               if (act[i]) begin
                  cnt_d[i] = '0;
               end else if (idle_thr_i != '0) begin
                  if (cnt_inc >= {1'b0, idle_thr_i}) begin
                     state_d[i] = ST_DRAIN;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_inc[CNT_W-1:0];
                  end
               end else begin
                  cnt_d[i] = '0;
               end
            end
            ST_DRAIN: state_d[i] = act[i] ? ST_ON : ST_OFF;
            ST_OFF:   if (act[i]) state_d[i] = ST_WAKE;
            ST_WAKE:  state_d[i] = ST_ON;
            default:  state_d[i] = ST_ON;
         endcase
      end
   end

   // Enables are registered from the next state so they change on the same edge as the FSM.
   always_comb begin
      en_d    = '0;
      ready_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         en_d[i]    = (state_d[i] != ST_OFF);
         ready_d[i] = (state_d[i] == ST_ON);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_ON;
            cnt_q[i]   <= '0;
         end
         en_q    <= '1;
         ready_q <= '1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         en_q    <= en_d;
         ready_q <= ready_d;
      end
   end

   assign en_o    = en_q;
   assign ready_o = ready_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_gate
`ifdef CKGATE_BYPASS_EN
      assign clk_o[g] = clk_i;
`else
      // Enable only changes while clk_i is low, so each gated pulse is either whole or absent.
      logic en_lat;
      always_latch begin
         if (!clk_i) en_lat <= en_q[g];
      end
      assign clk_o[g] = clk_i & en_lat;
`endif
   end

endmodule

// File: tb/tb_ckgate_ctrl.sv
// tb/tb_ckgate_ctrl.sv - scoreboard bench for ckgate_ctrl against a behavioural channel model
module tb_ckgate_ctrl;
   localparam int NCH = 4;
   localparam int CW  = 8;

   localparam int M_RUN   = 0;
   localparam int M_SETTLE = 1;
   localparam int M_STOP  = 2;
   localparam int M_START = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [CW-1:0]   thr;
   logic [NCH-1:0]  busy, wake, force_on;
   logic [NCH-1:0]  en_o, ready_o, clk_o;

   always #5 clk = ~clk;

   ckgate_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .idle_thr_i (thr),
      .busy_i     (busy),
      .wake_i     (wake),
      .force_on_i (force_on),
      .en_o       (en_o),
      .ready_o    (ready_o),
      .clk_o      (clk_o)
   );

   typedef struct {
      logic [NCH-1:0] en;
      logic [NCH-1:0] rdy;
      logic [NCH-1:0] pulse;
      bit             chk_clk;
      int             cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   int             m_mode [NCH];
   int             m_idle [NCH];
   logic [NCH-1:0] m_en    = '0;
   bit             m_known = 1'b0;

   // Reference: one edge of channel behaviour from the rules (idle run length vs threshold).
   task automatic model_edge(input bit r, input int t, input logic [NCH-1:0] a);
      for (int c = 0; c < NCH; c++) begin
         if (r) begin
            m_mode[c] = M_RUN;
            m_idle[c] = 0;
         end else if (m_mode[c] == M_RUN) begin
            if (a[c] || t == 0) m_idle[c] = 0;
            else if (m_idle[c] + 1 >= t) begin
               m_mode[c] = M_SETTLE;
               m_idle[c] = 0;
            end else m_idle[c] = m_idle[c] + 1;
         end else if (m_mode[c] == M_SETTLE) begin
            m_mode[c] = a[c] ? M_RUN : M_STOP;
         end else if (m_mode[c] == M_STOP) begin
            if (a[c]) m_mode[c] = M_START;
         end else begin
            m_mode[c] = M_RUN;
         end
      end
   endtask

   task automatic drive(input bit r, input int t, input logic [NCH-1:0] b,
                        input logic [NCH-1:0] w, input logic [NCH-1:0] f);
      exp_t e;
      rst = r; thr = CW'(t); busy = b; wake = w; force_on = f;
      e.chk_clk = m_known;
`ifdef CKGATE_BYPASS_EN
      e.pulse = '1;
`else
      e.pulse = m_en;
`endif
      model_edge(r, t, b | w | f);
      for (int c = 0; c < NCH; c++) begin
         e.en[c]  = (m_mode[c] != M_STOP);
         e.rdy[c] = (m_mode[c] == M_RUN);
      end
      m_en    = e.en;
      m_known = 1'b1;
      e.cyc   = cyc;
      cyc++;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [NCH-1:0] rnd_vec(input int p);
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(p - 1) == 0);
      return v;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk++;
            if (en_o !== e.en) begin
               n_fail++;
               $display("FAIL en_o cycle %0d: got %b expected %b", e.cyc, en_o, e.en);
            end
            n_chk++;
            if (ready_o !== e.rdy) begin
               n_fail++;
               $display("FAIL ready_o cycle %0d: got %b expected %b", e.cyc, ready_o, e.rdy);
            end
            if (e.chk_clk) begin
               n_chk++;
               if (clk_o !== e.pulse) begin
                  n_fail++;
                  $display("FAIL clk_o pulse cycle %0d: got %b expected %b", e.cyc, clk_o, e.pulse);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int t;
      rst = 1'b1; thr = '0; busy = '0; wake = '0; force_on = '0;
      for (int c = 0; c < NCH; c++) begin
         m_mode[c] = M_RUN;
         m_idle[c] = 0;
      end
      // Reset release with threshold 4: gate after 4 idle edges, off after 5.
      drive(1, 4, '0, '0, '0);
      drive(1, 4, '0, '0, '0);
      for (int i = 0; i < 10; i++) drive(0, 4, '0, '0, '0);
      // One-cycle wake on channel 1.
      drive(0, 4, '0, 4'b0010, '0);
      for (int i = 0; i < 8; i++) drive(0, 4, '0, '0, '0);
      // Wake everything, let it reach DRAIN, then busy on channel 2 during DRAIN.
      drive(0, 4, '0, 4'hf, '0);
      for (int i = 0; i < 5; i++) drive(0, 4, '0, '0, '0);
      drive(0, 4, 4'b0100, '0, '0);
      for (int i = 0; i < 8; i++) drive(0, 4, '0, '0, '0);
      // Threshold 0 disables gating; then threshold 1 gates quickly.
      drive(1, 0, '0, '0, '0);
      for (int i = 0; i < 100; i++) drive(0, 0, '0, '0, '0);
      for (int i = 0; i < 4; i++) drive(0, 1, '0, '0, '0);
      // Force channel 3 on while the others gate.
      drive(0, 1, '0, 4'hf, 4'b1000);
      for (int i = 0; i < 20; i++) drive(0, 1, '0, '0, 4'b1000);
      // Reset with channels in OFF and WAKE.
      drive(0, 1, '0, 4'b0001, '0);
      drive(1, 1, '0, '0, '0);
      for (int i = 0; i < 4; i++) drive(0, 1, '0, '0, '0);
      // Randomised traffic, threshold changes and occasional reset.
      t = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) t = $urandom_range(7);
         drive(($urandom_range(99) == 0), t, rnd_vec(8), rnd_vec(24), rnd_vec(40));
      end
      for (int i = 0; i < 4; i++) drive(0, 2, '0, '0, '0);
      repeat (3) @(negedge clk);
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
